// File: rtl/out_port_arbiter.sv
// out_port_arbiter: two-way round-robin scheduler for one router output link.
// Arbitrates between the switch-traversal flit and the local injection flit,
// gated by a credit counter that mirrors free slots in the downstream queue,
// and registers the winning flit onto the link.
module out_port_arbiter #(
  parameter int unsigned FLIT_SIZE    = 82,
  parameter int unsigned VALID_BIT    = 81,
  parameter int unsigned INIT_CREDITS = 5,
  parameter int unsigned CREDIT_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_SIZE-1:0] sw_flit,
  input  logic                 sw_valid,
  output logic                 sw_grant,
  input  logic [FLIT_SIZE-1:0] inj_flit,
  input  logic                 inj_valid,
  output logic                 inj_grant,
  input  logic                 credit_return,
  output logic [FLIT_SIZE-1:0] out_flit,
  output logic                 out_valid,
  output logic [CREDIT_W-1:0]  credits,
  output logic                 credit_err
);

  localparam logic [CREDIT_W-1:0] CRED_MAX = CREDIT_W'(INIT_CREDITS);

  // 0 = switch won the last grant, 1 = inject won the last grant
  logic last;
  logic req_sw;
  logic req_inj;
  logic can_send;
  logic grant_any;

  // Same-cycle arbitration; a tie goes to whoever did not win last time
  always_comb begin
    req_sw    = sw_valid & sw_flit[VALID_BIT];
    req_inj   = inj_valid & inj_flit[VALID_BIT];
    can_send  = (credits != '0);
    sw_grant  = 1'b0;
    inj_grant = 1'b0;
    if (!rst && can_send) begin
      if (req_sw && (!req_inj || last)) begin
        sw_grant = 1'b1;
      end else if (req_inj) begin
        inj_grant = 1'b1;
      end
    end
    grant_any = sw_grant | inj_grant;
  end

  // Link register and round-robin pointer; flit holds when nothing is granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last      <= 1'b1;
      out_valid <= 1'b0;
      out_flit  <= '0;
    end else begin
      out_valid <= grant_any;
      if (grant_any) begin
        last     <= inj_grant;
        out_flit <= sw_grant ? sw_flit : inj_flit;
      end
    end
  end

  // Credit counter: grant consumes, return restores, overlap cancels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits    <= CRED_MAX;
      credit_err <= 1'b0;
    end else begin
      case ({grant_any, credit_return})
        2'b10: credits <= credits - CREDIT_W'(1);
        2'b01: begin
          if (credits == CRED_MAX) begin
            credit_err <= 1'b1;
          end else begin
            credits <= credits + CREDIT_W'(1);
          end
        end
        default: credits <= credits;
      endcase
    end
  end

endmodule

// File: tb/tb_out_port_arbiter.sv
// tb_out_port_arbiter: directed table-driven bench for out_port_arbiter.
// Each table row describes one clock cycle: the inputs driven in that cycle,
// the expected combinational grants, and the registered outputs visible then.
module tb_out_port_arbiter;

  localparam int unsigned FW = 82;

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] sw_flit;
  logic          sw_valid;
  logic          sw_grant;
  logic [FW-1:0] inj_flit;
  logic          inj_valid;
  logic          inj_grant;
  logic          credit_return;
  logic [FW-1:0] out_flit;
  logic          out_valid;
  logic [2:0]    credits;
  logic          credit_err;

  int n_checks = 0;
  int n_fail   = 0;

  out_port_arbiter #(
    .FLIT_SIZE(82), .VALID_BIT(81), .INIT_CREDITS(5), .CREDIT_W(3)
  ) dut (
    .clk(clk), .rst(rst),
    .sw_flit(sw_flit), .sw_valid(sw_valid), .sw_grant(sw_grant),
    .inj_flit(inj_flit), .inj_valid(inj_valid), .inj_grant(inj_grant),
    .credit_return(credit_return),
    .out_flit(out_flit), .out_valid(out_valid),
    .credits(credits), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sv;   logic svb; logic [7:0] st;
    logic       iv;   logic ivb; logic [7:0] it;
    logic       cr;
    logic       esg;  logic eig;
    logic       eov;  logic [7:0] etag;
    logic [2:0] ecr;  logic eerr;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [FW-1:0] mk(input logic vb, input logic [7:0] tag);
    return {vb, 73'b0, tag};
  endfunction

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic sv, input logic svb, input logic [7:0] st,
                     input logic iv, input logic ivb, input logic [7:0] it,
                     input logic cr, input logic esg, input logic eig,
                     input logic eov, input logic [7:0] etag,
                     input logic [2:0] ecr, input logic eerr);
    vec_t v;
    v.sv = sv; v.svb = svb; v.st = st; v.iv = iv; v.ivb = ivb; v.it = it;
    v.cr = cr; v.esg = esg; v.eig = eig; v.eov = eov; v.etag = etag;
    v.ecr = ecr; v.eerr = eerr;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic sv, input logic svb, input logic [7:0] st,
                       input logic iv, input logic ivb, input logic [7:0] it,
                       input logic cr);
    sw_valid = sv; sw_flit = mk(svb, st);
    inj_valid = iv; inj_flit = mk(ivb, it);
    credit_return = cr;
  endtask

  initial begin
    // Cycle table (sv svb st | iv ivb it | cr | esg eig | eov etag | ecr eerr)
    // Switch-only stream drains the 5 credits, 6th flit waits for a return
    add(1,1,8'h11, 0,0,8'h00, 0, 1,0, 0,8'h00, 3'd5, 0);
    add(1,1,8'h12, 0,0,8'h00, 0, 1,0, 1,8'h11, 3'd4, 0);
    add(1,1,8'h13, 0,0,8'h00, 0, 1,0, 1,8'h12, 3'd3, 0);
    add(1,1,8'h14, 0,0,8'h00, 0, 1,0, 1,8'h13, 3'd2, 0);
    add(1,1,8'h15, 0,0,8'h00, 0, 1,0, 1,8'h14, 3'd1, 0);
    add(1,1,8'h16, 0,0,8'h00, 0, 0,0, 1,8'h15, 3'd0, 0);
    add(1,1,8'h16, 0,0,8'h00, 1, 0,0, 0,8'h00, 3'd0, 0);
    add(1,1,8'h16, 0,0,8'h00, 0, 1,0, 0,8'h00, 3'd1, 0);
    add(0,0,8'h00, 0,0,8'h00, 0, 0,0, 1,8'h16, 3'd0, 0);
    // Refill to 5 credits
    add(0,0,8'h00, 0,0,8'h00, 1, 0,0, 0,8'h00, 3'd0, 0);
    add(0,0,8'h00, 0,0,8'h00, 1, 0,0, 0,8'h00, 3'd1, 0);
    add(0,0,8'h00, 0,0,8'h00, 1, 0,0, 0,8'h00, 3'd2, 0);
    add(0,0,8'h00, 0,0,8'h00, 1, 0,0, 0,8'h00, 3'd3, 0);
    add(0,0,8'h00, 0,0,8'h00, 1, 0,0, 0,8'h00, 3'd4, 0);
    add(0,0,8'h00, 0,0,8'h00, 0, 0,0, 0,8'h00, 3'd5, 0);
    // Inject-only grant overlapping a return, then sustained contention
    add(0,0,8'h00, 1,1,8'hA0, 1, 0,1, 0,8'h00, 3'd5, 0);
    add(1,1,8'h17, 1,1,8'hA1, 1, 1,0, 1,8'hA0, 3'd5, 0);
    add(1,1,8'h18, 1,1,8'hA1, 1, 0,1, 1,8'h17, 3'd5, 0);
    add(1,1,8'h18, 1,1,8'hA2, 1, 1,0, 1,8'hA1, 3'd5, 0);
    add(1,1,8'h19, 1,1,8'hA2, 1, 0,1, 1,8'h18, 3'd5, 0);
    add(0,0,8'h00, 0,0,8'h00, 0, 0,0, 1,8'hA2, 3'd5, 0);
    add(0,0,8'h00, 0,0,8'h00, 0, 0,0, 0,8'h00, 3'd5, 0);
    // Strobes without the in-flit valid bit are ignored
    add(0,0,8'h00, 1,0,8'h55, 0, 0,0, 0,8'h00, 3'd5, 0);
    add(0,0,8'h00, 1,0,8'h55, 0, 0,0, 0,8'h00, 3'd5, 0);
    add(1,0,8'h66, 1,0,8'h55, 0, 0,0, 0,8'h00, 3'd5, 0);
    add(0,0,8'h00, 0,0,8'h00, 0, 0,0, 0,8'h00, 3'd5, 0);
    // Return at full credits: saturate and raise sticky error
    add(0,0,8'h00, 0,0,8'h00, 1, 0,0, 0,8'h00, 3'd5, 0);
    add(0,0,8'h00, 0,0,8'h00, 0, 0,0, 0,8'h00, 3'd5, 1);
    add(0,0,8'h00, 0,0,8'h00, 0, 0,0, 0,8'h00, 3'd5, 1);

    // Reset with requests present: grants must stay low
    rst = 1'b1;
    drive(1,1,8'h01, 1,1,8'h02, 0);
    #1;
    chk("rst_sw_grant", FW'(sw_grant), FW'(0));
    chk("rst_inj_grant", FW'(inj_grant), FW'(0));
    chk("rst_out_valid", FW'(out_valid), FW'(0));
    chk("rst_out_flit", out_flit, FW'(0));
    chk("rst_credits", FW'(credits), FW'(5));
    chk("rst_credit_err", FW'(credit_err), FW'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(0,0,8'h00, 0,0,8'h00, 0);
    rst = 1'b0;

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("idle_grants", FW'({sw_grant, inj_grant}), FW'(0));
      chk("idle_out_valid", FW'(out_valid), FW'(0));
      chk("idle_credits", FW'(credits), FW'(5));
      chk("idle_credit_err", FW'(credit_err), FW'(0));
    end

    // Table-driven cycles
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].sv, vecs[i].svb, vecs[i].st, vecs[i].iv, vecs[i].ivb, vecs[i].it, vecs[i].cr);
      #1;
      chk($sformatf("v%0d_sw_grant", i), FW'(sw_grant), FW'(vecs[i].esg));
      chk($sformatf("v%0d_inj_grant", i), FW'(inj_grant), FW'(vecs[i].eig));
      chk($sformatf("v%0d_out_valid", i), FW'(out_valid), FW'(vecs[i].eov));
      if (vecs[i].eov)
        chk($sformatf("v%0d_out_flit", i), out_flit, mk(1'b1, vecs[i].etag));
      chk($sformatf("v%0d_credits", i), FW'(credits), FW'(vecs[i].ecr));
      chk($sformatf("v%0d_credit_err", i), FW'(credit_err), FW'(vecs[i].eerr));
    end

    // Mid-stream reset at credits=2 with out_valid=1
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1,1,8'h21 + 8'(i), 0,0,8'h00, 0);
      #1;
      chk($sformatf("pre_rst_sw_grant%0d", i), FW'(sw_grant), FW'(1));
    end
    @(negedge clk);
    drive(1,1,8'h24, 1,1,8'hB0, 0);
    #1;
    chk("pre_rst_credits", FW'(credits), FW'(2));
    chk("pre_rst_out_valid", FW'(out_valid), FW'(1));
    chk("pre_rst_out_flit", out_flit, mk(1'b1, 8'h23));
    chk("pre_rst_credit_err", FW'(credit_err), FW'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", FW'(out_valid), FW'(0));
    chk("mid_rst_out_flit", out_flit, FW'(0));
    chk("mid_rst_credits", FW'(credits), FW'(5));
    chk("mid_rst_credit_err", FW'(credit_err), FW'(0));
    chk("mid_rst_grants", FW'({sw_grant, inj_grant}), FW'(0));
    @(posedge clk); #1;
    chk("held_rst_credits", FW'(credits), FW'(5));
    chk("held_rst_out_valid", FW'(out_valid), FW'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_tie_sw", FW'(sw_grant), FW'(1));
    chk("post_rst_tie_inj", FW'(inj_grant), FW'(0));
    @(negedge clk);
    drive(1,1,8'h25, 1,1,8'hB0, 0);
    #1;
    chk("post_rst_out_flit", out_flit, mk(1'b1, 8'h24));
    chk("post_rst_next_inj", FW'(inj_grant), FW'(1));
    chk("post_rst_credits", FW'(credits), FW'(4));
    @(negedge clk);
    drive(0,0,8'h00, 0,0,8'h00, 0);
    #1;
    chk("post_rst_inj_flit", out_flit, mk(1'b1, 8'hB0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/out_port_arbiter.md
# out_port_arbiter

Per-output-port scheduler between the switch-traversal stage and the local injection port of one router output (MGT) link. It replaces the fixed inject-wins output mux, which silently drops switch flits. Each cycle it grants at most one requester using two-way round-robin. Grants are gated by a credit counter that tracks free slots in the downstream neighbour's input queue, and the selected flit is registered onto the link.

## Interface
Parameters:
- FLIT_SIZE, 82, flit width in bits.
- VALID_BIT, 81, index of the in-flit valid bit.
- INIT_CREDITS, 5, downstream input-queue depth (equals input_Q_size); credit counter reset value.
- CREDIT_W, 3, credit counter width; must hold INIT_CREDITS.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- sw_flit  in  FLIT_SIZE  flit from switch output for this port.
- sw_valid  in  1  switch flit present.
- sw_grant  out  1  switch flit accepted this cycle (consume pulse to the switch-side queue).
- inj_flit  in  FLIT_SIZE  flit from application kernel.
- inj_valid  in  1  injection flit present.
- inj_grant  out  1  injection flit accepted this cycle.
- credit_return  in  1  one-cycle pulse: downstream freed one slot.
- out_flit  out  FLIT_SIZE  registered link flit.
- out_valid  out  1  registered link valid.
- credits  out  CREDIT_W  current credit count (debug).
- credit_err  out  1  sticky: credit_return arrived while count was already INIT_CREDITS.

## Operation
- Effective request: req_sw = sw_valid & sw_flit[VALID_BIT]; req_inj = inj_valid & inj_flit[VALID_BIT]. A valid strobe without the flit valid bit is ignored and never granted.
- can_send = (credits != 0).
- Arbitration is combinational in the same cycle, with a single pointer `last`: 0 = switch won last, 1 = inject won last.
  - If only one requester is active and can_send, that requester is granted.
  - If both are active and can_send, the requester other than `last` is granted.
  - If neither is active, or can_send=0, no grant is issued and `last` is unchanged.
- On grant: `last` <= winner; out_flit <= winner's flit; out_valid <= 1.
- With no grant: out_valid <= 0 and out_flit holds its value.
- sw_grant and inj_grant are never both 1.
- A requester that is not granted must hold its flit and valid stable. The arbiter never drops a requested flit.
- Credit update each cycle, with g = sw_grant|inj_grant and r = credit_return:
  - g & ~r: credits - 1.
  - ~g & r: credits + 1, saturating at INIT_CREDITS. If credits was already INIT_CREDITS, credits stays and credit_err <= 1.
  - g & r, or neither: unchanged.
- A credit_return arriving while credits==0 takes effect next cycle. It does not enable a grant in the same cycle.
- credit_err clears only on rst.

## Timing
- Reset values:
  - out_flit = 0, out_valid = 0.
  - credits = INIT_CREDITS.
  - `last` = 1, so the switch wins the first tie.
  - credit_err = 0.
  - sw_grant and inj_grant are 0 while rst is asserted.
- Grant-to-link latency: 1 cycle. A grant in cycle N gives out_valid=1 with that flit in cycle N+1.
- Back-to-back grants are allowed every cycle while credits remain. Sustained throughput is 1 flit/cycle.
- Under sustained contention with ample credits, grants alternate strictly: sw, inj, sw, inj, …
- With credits=0, grants are 0 combinationally in the same cycle the counter reads 0.
- Reset asserted mid-stream aborts immediately:
  - Registered outputs clear asynchronously.
  - A grant pulse coincident with the rst edge is not counted.
  - The credit count restores to INIT_CREDITS. Downstream queues are reset by the same rst.

## Test plan
- Reset, then idle: out_valid=0, credits=5, credit_err=0, no grants for 10 cycles.
- Switch-only stream, 5 flits on consecutive cycles, no credit_return:
  - sw_grant is high for 5 cycles, out_valid high 1 cycle later for 5 cycles, credits steps 5→0.
  - A 6th flit is held with sw_grant=0.
  - One credit_return pulse yields the 6th grant the following cycle.
- Both requesting continuously with credit_return pulsed every cycle:
  - Grants are sw, inj, sw, inj…, out_flit alternates accordingly, and credits stays at 5 after the first grant/return overlap.
- inj_valid=1 with inj_flit[81]=0 while the switch is idle: no grant, out_valid stays 0, credits unchanged.
- Credit overflow: credit_return pulse at credits=5 → credits stays 5, credit_err=1 and stays 1 until rst.
- rst asserted at credits=2 with out_valid=1 → out_valid=0 and credits=5 immediately. After release, the first tie goes to the switch.
